// File: rtl/matrix_pkg.sv
// Shared defaults, derived widths and FSM state type for the matrix write path.
package matrix_pkg;

  localparam int NUM_REQ_DEF      = 4;
  localparam int MAX_ELEMENT_SIZE = 8;
  localparam int MAX_SIZE_A       = 32;
  localparam int MAX_SIZE_B       = 32;

  localparam int ROW_W = $clog2(MAX_SIZE_A);
  localparam int COL_W = $clog2(MAX_SIZE_B);
  localparam int IDX_W = $clog2(MAX_SIZE_A * MAX_SIZE_B);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    WAIT_TX = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant from the first request at or after ptr.
// Zero latency; ptr moves past the winner only when the consumer takes the grant (advance).
module rr_arbiter #(
  parameter int  N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] ptr;
  logic [31:0]   cand;
  logic          found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = 32'(ptr) + 32'(k);
      if (cand >= 32'(N)) cand = cand - 32'(N);
      if (!found && req[IW'(cand)]) begin
        found                = 1'b1;
        grant[IW'(cand)]     = 1'b1;
        grant_idx            = IW'(cand);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);
    end
  end

endmodule

// File: rtl/matrix_write_arbiter.sv
// Arbitrates producers onto the single element-write port (1-cycle registered write), tracks filled
// cells and blocks all writers after a full load until tx completes. Stats: MATRIX_WRITE_ARB_STATS_EN.
module matrix_write_arbiter #(
  parameter int  NUM_REQ          = matrix_pkg::NUM_REQ_DEF,
  parameter int  MAX_ELEMENT_SIZE = matrix_pkg::MAX_ELEMENT_SIZE,
  parameter int  MAX_SIZE_A       = matrix_pkg::MAX_SIZE_A,
  parameter int  MAX_SIZE_B       = matrix_pkg::MAX_SIZE_B,
  localparam int ROW_W            = $clog2(MAX_SIZE_A),
  localparam int COL_W            = $clog2(MAX_SIZE_B),
  localparam int GNT_W            = $clog2(NUM_REQ),
  localparam int CNT_W            = $clog2(MAX_SIZE_A * MAX_SIZE_B) + 1
) (
  input  logic                          inter_refclk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ROW_W-1:0]      req_row,
  input  logic [NUM_REQ*COL_W-1:0]      req_col,
  input  logic [NUM_REQ*MAX_ELEMENT_SIZE-1:0] req_data,
  input  logic                          tx_busy,
  output logic                          valid_data_out,
  output logic [ROW_W-1:0]              row_addr,
  output logic [COL_W-1:0]              col_addr,
  output logic [MAX_ELEMENT_SIZE-1:0]   matrix_element,
  output logic [GNT_W-1:0]              grant_id,
  output logic [CNT_W-1:0]              filled_count,
  output logic                          load_done,
  output logic                          busy
`ifdef MATRIX_WRITE_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]         accept_count,
  output logic [15:0]                   dup_count
`endif
);

  import matrix_pkg::*;

  localparam int CELLS = MAX_SIZE_A * MAX_SIZE_B;
  localparam int IDX_W = $clog2(CELLS);

  state_t                      state, state_next;
  logic                        seen_rise;
  logic                        accepting, accept, win_dup, full_next, clear_fill;
  logic [NUM_REQ-1:0]          in_range, eligible, grant;
  logic [GNT_W-1:0]            win;
  logic [ROW_W-1:0]            row_a  [NUM_REQ];
  logic [COL_W-1:0]            col_a  [NUM_REQ];
  logic [MAX_ELEMENT_SIZE-1:0] data_a [NUM_REQ];
  logic [IDX_W-1:0]            win_idx;
  logic [CNT_W-1:0]            count_next;
  logic [CELLS-1:0]            fill_map;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign row_a[i]    = req_row[i*ROW_W +: ROW_W];
    assign col_a[i]    = req_col[i*COL_W +: COL_W];
    assign data_a[i]   = req_data[i*MAX_ELEMENT_SIZE +: MAX_ELEMENT_SIZE];
    assign in_range[i] = (32'(row_a[i]) < MAX_SIZE_A) && (32'(col_a[i]) < MAX_SIZE_B);
  end

  // rst_n gates the offer so req_ready reads 0 while reset is held
  assign accepting = rst_n && (state != WAIT_TX);
  assign eligible  = req_valid & in_range & {NUM_REQ{accepting}};
  assign accept    = |grant;
  assign req_ready = grant;
  assign busy      = (state != IDLE);

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk       (inter_refclk),
    .rst_n     (rst_n),
    .req       (eligible),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (win)
  );

  assign win_idx    = IDX_W'(row_a[win]) * IDX_W'(MAX_SIZE_B) + IDX_W'(col_a[win]);
  assign win_dup    = fill_map[win_idx];
  assign count_next = (accept && !win_dup) ? filled_count + CNT_W'(1) : filled_count;
  assign full_next  = (count_next == CNT_W'(CELLS));
  assign clear_fill = (state == WAIT_TX) && seen_rise && !tx_busy;

  always_ff @(posedge inter_refclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = full_next ? WAIT_TX : LOAD;
      LOAD:    if (full_next) state_next = WAIT_TX;
      WAIT_TX: if (clear_fill) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // tx_busy already high in the first WAIT_TX cycle counts as the rising edge
  always_ff @(posedge inter_refclk or negedge rst_n) begin
    if (!rst_n) seen_rise <= 1'b0;
    else        seen_rise <= (state == WAIT_TX) && !clear_fill && (seen_rise || tx_busy);
  end

  always_ff @(posedge inter_refclk or negedge rst_n) begin
    if (!rst_n) begin
      valid_data_out <= 1'b0;
      load_done      <= 1'b0;
      row_addr       <= '0;
      col_addr       <= '0;
      matrix_element <= '0;
      grant_id       <= '0;
      filled_count   <= '0;
      fill_map       <= '0;
    end else begin
      valid_data_out <= accept;
      load_done      <= accept && full_next;
      if (accept) begin
        row_addr       <= row_a[win];
        col_addr       <= col_a[win];
        matrix_element <= data_a[win];
        grant_id       <= win;
      end
      if (clear_fill) begin
        fill_map     <= '0;
        filled_count <= '0;
      end else if (accept) begin
        fill_map[win_idx] <= 1'b1;
        filled_count      <= count_next;
      end
    end
  end

`ifdef MATRIX_WRITE_ARB_STATS_EN
  always_ff @(posedge inter_refclk or negedge rst_n) begin
    if (!rst_n) begin
      accept_count <= '0;
      dup_count    <= '0;
    end else if (clear_fill) begin
      accept_count <= '0;
      dup_count    <= '0;
    end else if (accept) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i] && accept_count[i*16 +: 16] != 16'hFFFF)
          accept_count[i*16 +: 16] <= accept_count[i*16 +: 16] + 16'd1;
      end
      if (win_dup && dup_count != 16'hFFFF) dup_count <= dup_count + 16'd1;
    end
  end
`endif

endmodule
